// File: rtl/valve_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : valve_seq_pkg
//  Purpose  : Shared types and constants for the valve step sequencer:
//             FSM state encoding, delay unit codes and step-word layout.
//  Revision : 1.0  initial release
// ============================================================================
package valve_seq_pkg;

   // FSM state encoding (explicit 3-bit width)
   localparam int STATE_W = 3;
   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_ARM   = 3'd3,
      S_WAIT  = 3'd4,
      S_NEXT  = 3'd5,
      S_DONE  = 3'd6,
      S_ERR   = 3'd7
   } state_t;

   // Delay unit codes understood by the delay counter
   localparam logic [2:0] UNIT_MS  = 3'd0;
   localparam logic [2:0] UNIT_S   = 3'd1;
   localparam logic [2:0] UNIT_MIN = 3'd2;
   localparam logic [2:0] UNIT_HR  = 3'd3;
   localparam logic [2:0] UNIT_DAY = 3'd4;
   localparam logic [2:0] UNIT_MAX = UNIT_DAY;

   // Step word layout: {valve mask, delay[5:0], unit[2:0]}
   localparam int UNIT_LSB = 0;
   localparam int UNIT_W   = 3;
   localparam int DLY_LSB  = 3;
   localparam int DLY_W    = 6;
   localparam int MASK_LSB = 9;

   // Codes 5..7 have no meaning to the counter and abort the program
   function automatic logic unit_legal(input logic [2:0] u);
      return (u <= UNIT_MAX);
   endfunction

endpackage
`default_nettype wire

// File: rtl/valve_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : valve_sequencer
//  Purpose  : Walks a program of {valve mask, delay, unit} steps from an
//             external step memory, drives the valve array and sequences the
//             shared delay counter (clear + arm, then wait for its done flag).
//  Revision : 1.0  initial release
// ============================================================================
module valve_sequencer
   import valve_seq_pkg::*;
#(
   parameter int NVALVE  = 16,
   parameter int STEP_AW = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  loop_en,
   input  logic [STEP_AW:0]      prog_len,
   output logic [STEP_AW-1:0]    step_addr,
   input  logic [NVALVE+8:0]     step_data,
   output logic [5:0]            delay,
   output logic [2:0]            delay_unit,
   output logic                  timer_clr,
   output logic                  delay_start,
   input  logic                  count_done,
   output logic [NVALVE-1:0]     valve_out,
   output logic [STEP_AW-1:0]    cur_step,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [STEP_AW:0] c_idx_one = {{STEP_AW{1'b0}}, 1'b1};

   state_t               r_state,  w_state_nxt;
   logic [STEP_AW:0]     r_idx,    w_idx_nxt;
   logic [STEP_AW:0]     r_len,    w_len_nxt;
   logic [STEP_AW-1:0]   r_addr,   w_addr_nxt;
   logic [STEP_AW-1:0]   r_cur,    w_cur_nxt;
   logic [NVALVE-1:0]    r_valve,  w_valve_nxt;
   logic [5:0]           r_delay,  w_delay_nxt;
   logic [2:0]           r_unit,   w_unit_nxt;
   logic                 r_clr,    w_clr_nxt;
   logic                 r_dstart, w_dstart_nxt;
   logic                 r_busy,   w_busy_nxt;
   logic                 r_done,   w_done_nxt;
   logic                 r_err,    w_err_nxt;

   // Step word fields
   logic [NVALVE-1:0]    w_mask;
   logic [DLY_W-1:0]     w_dly_f;
   logic [UNIT_W-1:0]    w_unit_f;
   logic [STEP_AW:0]     w_idx_inc;
   logic                 w_last;

   assign w_mask    = step_data[MASK_LSB +: NVALVE];
   assign w_dly_f   = step_data[DLY_LSB  +: DLY_W];
   assign w_unit_f  = step_data[UNIT_LSB +: UNIT_W];
   assign w_idx_inc = r_idx + c_idx_one;
   // Index math is one bit wider than the address so a full 2^STEP_AW
   // program compares correctly against its last index
   assign w_last    = (r_idx == (r_len - c_idx_one));

   // Next-state and next-output logic; every output is registered, so
   // one-cycle pulses are set on the transition into the cycle they mark
   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_len_nxt    = r_len;
      w_addr_nxt   = r_addr;
      w_cur_nxt    = r_cur;
      w_valve_nxt  = r_valve;
      w_delay_nxt  = r_delay;
      w_unit_nxt   = r_unit;
      w_err_nxt    = r_err;
      w_clr_nxt    = 1'b0;
      w_dstart_nxt = 1'b0;
      w_done_nxt   = 1'b0;

      if (abort) begin
         w_state_nxt = S_IDLE;
         w_valve_nxt = '0;
         w_err_nxt   = 1'b0;
         w_clr_nxt   = 1'b1;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  w_err_nxt = 1'b0;
                  w_len_nxt = prog_len;
                  if (prog_len == '0) begin
                     w_state_nxt = S_DONE;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = S_FETCH;
                     w_idx_nxt   = '0;
                     w_addr_nxt  = '0;
                     w_cur_nxt   = '0;
                  end
               end
            end
            S_FETCH: w_state_nxt = S_LOAD;
            S_LOAD: begin
               if (!unit_legal(w_unit_f)) begin
                  w_state_nxt = S_ERR;
                  w_valve_nxt = '0;
                  w_err_nxt   = 1'b1;
               end else begin
                  w_state_nxt  = S_ARM;
                  w_valve_nxt  = w_mask;
                  w_delay_nxt  = w_dly_f;
                  w_unit_nxt   = w_unit_f;
                  // Pulses land in the ARM cycle itself
                  w_clr_nxt    = 1'b1;
                  w_dstart_nxt = 1'b1;
               end
            end
            S_ARM: w_state_nxt = S_WAIT;
            S_WAIT: begin
               if (count_done) w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
               if (!w_last) begin
                  w_state_nxt = S_FETCH;
                  w_idx_nxt   = w_idx_inc;
                  w_addr_nxt  = w_idx_inc[STEP_AW-1:0];
                  w_cur_nxt   = w_idx_inc[STEP_AW-1:0];
               end else if (loop_en) begin
                  w_state_nxt = S_FETCH;
                  w_idx_nxt   = '0;
                  w_addr_nxt  = '0;
                  w_cur_nxt   = '0;
               end else begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end

      w_busy_nxt = (w_state_nxt inside {S_FETCH, S_LOAD, S_ARM, S_WAIT, S_NEXT});
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_len    <= '0;
         r_addr   <= '0;
         r_cur    <= '0;
         r_valve  <= '0;
         r_delay  <= '0;
         r_unit   <= '0;
         r_clr    <= 1'b0;
         r_dstart <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_idx    <= w_idx_nxt;
         r_len    <= w_len_nxt;
         r_addr   <= w_addr_nxt;
         r_cur    <= w_cur_nxt;
         r_valve  <= w_valve_nxt;
         r_delay  <= w_delay_nxt;
         r_unit   <= w_unit_nxt;
         r_clr    <= w_clr_nxt;
         r_dstart <= w_dstart_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign step_addr   = r_addr;
   assign delay       = r_delay;
   assign delay_unit  = r_unit;
   assign timer_clr   = r_clr;
   assign delay_start = r_dstart;
   assign valve_out   = r_valve;
   assign cur_step    = r_cur;
   assign busy        = r_busy;
   assign done        = r_done;
   assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_valve_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_valve_sequencer
//  Purpose  : Self-checking bench for valve_sequencer with a step memory,
//             a simple delay-counter stand-in and a timeline reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_valve_sequencer;
   import valve_seq_pkg::*;

   localparam int NV   = 16;
   localparam int AW   = 5;
   localparam int MAXR = 1024;

   logic            clk = 1'b0;
   logic            rst, start, abort, loop_en;
   logic [AW:0]     prog_len;
   logic [AW-1:0]   step_addr, cur_step;
   logic [NV+8:0]   step_data;
   logic [5:0]      delay;
   logic [2:0]      delay_unit;
   logic            timer_clr, delay_start, count_done;
   logic [NV-1:0]   valve_out;
   logic            busy, done, err;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   valve_sequencer #(.NVALVE(NV), .STEP_AW(AW)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_en(loop_en),
      .prog_len(prog_len), .step_addr(step_addr), .step_data(step_data),
      .delay(delay), .delay_unit(delay_unit), .timer_clr(timer_clr),
      .delay_start(delay_start), .count_done(count_done), .valve_out(valve_out),
      .cur_step(cur_step), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Step memory: registered read, data valid one cycle after the address
   logic [NV+8:0] mem [0:31];
   always @(posedge clk) step_data <= mem[step_addr];

   // Delay counter stand-in: every unit counts one tick per clock
   int unsigned cnt_rem;
   logic        cnt_run;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_done <= 1'b0; cnt_run <= 1'b0; cnt_rem <= 0;
      end else if (timer_clr) begin
         count_done <= 1'b0; cnt_run <= delay_start; cnt_rem <= delay;
      end else if (cnt_run) begin
         if (cnt_rem == 0) begin count_done <= 1'b1; cnt_run <= 1'b0; end
         else cnt_rem <= cnt_rem - 1;
      end
   end

   // Expected per-cycle timeline (index 0 = first cycle after start sampled)
   logic [NV-1:0] e_v    [0:MAXR-1];
   bit            e_busy [0:MAXR-1];
   bit            e_done [0:MAXR-1];
   bit            e_err  [0:MAXR-1];
   bit            e_ds   [0:MAXR-1];
   int            e_cur  [0:MAXR-1];
   logic [5:0]    e_dl   [0:MAXR-1];
   logic [2:0]    e_un   [0:MAXR-1];
   logic [NV-1:0] model_valve = '0;
   bit            model_busy  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_valve"}, 32'(valve_out), 32'h0);
      check({tag, "_addr"},  32'(step_addr), 32'h0);
      check({tag, "_delay"}, 32'(delay), 32'h0);
      check({tag, "_unit"},  32'(delay_unit), 32'h0);
      check({tag, "_clr"},   32'(timer_clr), 32'h0);
      check({tag, "_dstart"},32'(delay_start), 32'h0);
      check({tag, "_cur"},   32'(cur_step), 32'h0);
      check({tag, "_busy"},  32'(busy), 32'h0);
      check({tag, "_done"},  32'(done), 32'h0);
      check({tag, "_err"},   32'(err), 32'h0);
   endtask

   task automatic gen_prog(input int len, input int bad, input int maxd);
      logic [15:0] m;
      logic [5:0]  d;
      logic [2:0]  u;
      for (int i = 0; i < 32; i++) begin
         m = 16'($urandom);
         d = 6'($urandom_range(0, maxd));
         u = 3'($urandom_range(0, 4));
         if (i == bad) u = 3'($urandom_range(5, 7));
         mem[i] = {m, d, u};
      end
   endtask

   function automatic int total_cycles(input int len);
      int s = 0;
      for (int i = 0; i < len; i++) s += int'(mem[i][DLY_LSB +: DLY_W]) + 6;
      return s;
   endfunction

   // Each step occupies FETCH, LOAD, ARM, (delay+2) WAIT, NEXT = delay+6 cycles
   task automatic build_model(input int len, input bit lp, input int ncyc);
      int t, i, nt, d;
      logic [2:0]  u;
      logic [15:0] m;
      bit fin;
      for (int r = 0; r < ncyc; r++) begin
         e_v[r] = model_valve; e_busy[r] = 1; e_done[r] = 0; e_err[r] = 0;
         e_ds[r] = 0; e_cur[r] = -1; e_dl[r] = '0; e_un[r] = '0;
      end
      t = 0; i = 0; fin = 0;
      while (!fin && t < ncyc) begin
         m = mem[i][MASK_LSB +: NV];
         d = int'(mem[i][DLY_LSB +: DLY_W]);
         u = mem[i][UNIT_LSB +: UNIT_W];
         if (u > UNIT_MAX) begin
            for (int r = t + 2; r < ncyc; r++) begin
               e_busy[r] = 0; e_v[r] = '0; e_err[r] = 1;
            end
            fin = 1;
         end else begin
            for (int r = t + 2; r < ncyc; r++) e_v[r] = m;
            if (t + 2 < ncyc) begin
               e_ds[t+2] = 1; e_cur[t+2] = i; e_dl[t+2] = 6'(d); e_un[t+2] = u;
            end
            nt = t + d + 6;
            if (i == len - 1 && !lp) begin
               if (nt < ncyc) e_done[nt] = 1;
               for (int r = nt; r < ncyc; r++) e_busy[r] = 0;
               fin = 1;
            end
            i = (i == len - 1) ? 0 : i + 1;
            t = nt;
         end
      end
      model_valve = e_v[ncyc-1];
      model_busy  = e_busy[ncyc-1];
   endtask

   // Call at a falling edge; returns at the falling edge of the last checked cycle
   task automatic run(input int len, input bit lp, input int ncyc, input bit noise);
      build_model(len, lp, ncyc);
      prog_len = (AW+1)'(len);
      loop_en  = lp;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int r = 0; r < ncyc; r++) begin
         check("valve", 32'(valve_out), 32'(e_v[r]));
         check("busy",  32'(busy),      32'(e_busy[r]));
         check("done",  32'(done),      32'(e_done[r]));
         check("err",   32'(err),       32'(e_err[r]));
         check("dstart",32'(delay_start),32'(e_ds[r]));
         check("tclr",  32'(timer_clr), 32'(e_ds[r]));
         if (e_cur[r] >= 0) begin
            check("cur_step", 32'(cur_step),   32'(e_cur[r]));
            check("delay",    32'(delay),      32'(e_dl[r]));
            check("unit",     32'(delay_unit), 32'(e_un[r]));
         end
         // Start requests while busy must be ignored and must not re-latch prog_len
         if (noise && e_busy[r] && r < ncyc - 1 && $urandom_range(0, 5) == 0) begin
            start = 1'b1; prog_len = (AW+1)'($urandom);
         end else begin
            start = 1'b0;
         end
         if (r < ncyc - 1) @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic do_abort(input bit with_start);
      abort = 1'b1;
      if (with_start) begin start = 1'b1; prog_len = 6'd3; end
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      check("abort_valve", 32'(valve_out), 32'h0);
      check("abort_busy",  32'(busy), 32'h0);
      check("abort_done",  32'(done), 32'h0);
      check("abort_err",   32'(err), 32'h0);
      check("abort_clr",   32'(timer_clr), 32'h1);
      @(negedge clk);
      check("abort_clr_end", 32'(timer_clr), 32'h0);
      check("abort_idle",    32'(busy), 32'h0);
      check("abort_nodone",  32'(done), 32'h0);
      model_valve = '0; model_busy = 1'b0;
   endtask

   task automatic load_directed();
      mem[0] = {16'h0001, 6'd2, UNIT_MS};
      mem[1] = {16'h0003, 6'd0, UNIT_MS};
      mem[2] = {16'h8000, 6'd1, UNIT_MS};
   endtask

   initial begin
      logic [AW-1:0] sa;
      int len, bad, n, d0;
      bit lp;
      rst = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0; prog_len = '0;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b1;
      @(negedge clk);

      // Directed three-step program, single pass
      load_directed();
      run(3, 1'b0, total_cycles(3) + 4, 1'b1);
      check("final_mask", 32'(valve_out), 32'h8000);

      // Zero-length program from DONE: immediate done, nothing else moves
      sa = step_addr;
      prog_len = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("len0_done",  32'(done), 32'h1);
      check("len0_busy",  32'(busy), 32'h0);
      check("len0_valve", 32'(valve_out), 32'h8000);
      check("len0_addr",  32'(step_addr), 32'(sa));
      @(negedge clk);
      check("len0_pulse", 32'(done), 32'h0);

      // Same program looping: step 0 comes back, no done
      run(3, 1'b1, total_cycles(3) + 12, 1'b0);
      do_abort(1'b0);

      // Illegal unit on step 1, then a clean restart clears err
      gen_prog(3, 1, 3);
      d0 = int'(mem[0][DLY_LSB +: DLY_W]);
      run(3, 1'b0, d0 + 12, 1'b0);
      gen_prog(2, -1, 3);
      run(2, 1'b0, total_cycles(2) + 4, 1'b1);

      // Abort (with a simultaneous start) during WAIT of step 1
      gen_prog(3, -1, 3);
      d0 = int'(mem[0][DLY_LSB +: DLY_W]);
      run(3, 1'b0, d0 + 10, 1'b0);
      do_abort(1'b1);

      // Randomized programs
      for (int k = 0; k < 24; k++) begin
         len = $urandom_range(1, 6);
         lp  = 1'($urandom_range(0, 1));
         bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
         gen_prog(len, bad, 3);
         n = ($urandom_range(0, 1) == 1) ? total_cycles(len) + 4
                                         : int'($urandom_range(3, total_cycles(len)));
         run(len, lp, n, 1'b1);
         if (model_busy || $urandom_range(0, 3) == 0) do_abort(1'b0);
      end

      // Full-size program with looping: index wraps from 31 back to 0
      gen_prog(32, -1, 1);
      run(32, 1'b1, total_cycles(32) + 10, 1'b1);
      do_abort(1'b0);

      // Asynchronous reset in WAIT of step 0, between clock edges
      load_directed();
      run(3, 1'b0, 4, 1'b0);
      #2 rst = 1'b0;
      #1 check_reset("async");
      @(negedge clk);
      rst = 1'b1;
      model_valve = '0; model_busy = 1'b0;
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/valve_sequencer.md
# valve_sequencer

Step-program controller for the microfluidic valve array. It walks a small program of steps held in an external step memory. Each step is a valve mask plus a delay value and a delay unit. For each step it drives the valve outputs, then arms and clears the shared delay counter and waits for that counter's done flag before advancing. It sits between the top-level control/UART front end and the delay counter, and it owns that counter's clear and start lines.

## Interface
Parameters:
- `NVALVE`, 16: number of valve outputs.
- `STEP_AW`, 5: step-memory address width; maximum program length is 2^STEP_AW steps.

Ports:
- `clk`, in, 1: system clock, 1 kHz timer tick domain, same as the delay counter.
- `rst`, in, 1: reset, **asynchronous, active-low**.
- `start`, in, 1: level-sampled request to run the program; honoured only in IDLE, DONE or ERR.
- `abort`, in, 1: stop immediately and close all valves; highest priority.
- `loop_en`, in, 1: after the last step, restart at step 0 instead of finishing. Sampled at each wrap.
- `prog_len`, in, STEP_AW+1: number of steps; latched on `start`.
- `step_addr`, out, STEP_AW: step-memory read address.
- `step_data`, in, NVALVE+9: step word, valid one cycle after `step_addr`. Layout: [NVALVE+8:9] valve mask, [8:3] delay, [2:0] unit.
- `delay`, out, 6: delay value to the counter; held for the whole step.
- `delay_unit`, out, 3: unit code to the counter; held for the whole step.
- `timer_clr`, out, 1: one-cycle clear to the counter's reset input.
- `delay_start`, out, 1: one-cycle arm pulse to the counter.
- `count_done`, in, 1: counter completion flag; sticky until cleared.
- `valve_out`, out, NVALVE: registered valve drive; 1 = open.
- `cur_step`, out, STEP_AW: index of the step currently executing.
- `busy`, out, 1: high in FETCH, LOAD, ARM, WAIT and NEXT.
- `done`, out, 1: one-cycle pulse when the program completes.
- `err`, out, 1: illegal unit code encountered; held until the next `start` or `abort`.

## Operation
States and transitions:
- **IDLE**
  - `start` with `prog_len` ≠ 0: go to FETCH with index 0.
  - `start` with `prog_len` = 0: go to DONE and pulse `done`; valves unchanged.
- **FETCH**: drive `step_addr` = index; go to LOAD.
- **LOAD**: sample `step_data`.
  - Unit > 4: go to ERR.
  - Otherwise register the valve mask into `valve_out`, register `delay` and `delay_unit`, and go to ARM.
- **ARM**: `timer_clr` = 1 and `delay_start` = 1 for exactly this cycle; go to WAIT.
- **WAIT**: hold all outputs; stay until `count_done` = 1, then go to NEXT.
- **NEXT**
  - index < `prog_len`−1: increment the index and go to FETCH.
  - Last step with `loop_en` = 1: index = 0, go to FETCH.
  - Last step with `loop_en` = 0: pulse `done` and go to DONE.
- **DONE**: `valve_out` holds the final step's mask; `start` restarts the program.
- **ERR**: `valve_out` = 0 and `err` = 1; `start` clears `err` and restarts the program.

Unit codes: 0 = ms, 1 = s, 2 = min, 3 = hr, 4 = day; 5–7 are illegal.

A delay of 0 is legal. The counter completes in its first counting cycle, so the step lasts ARM + 2 cycles.

Boundary and priority rules:
- `abort` in any state: next state IDLE, `valve_out` = 0, `err` = 0, `timer_clr` pulses once, no `done` pulse.
- `abort` and `start` in the same cycle: `abort` wins.
- `start` while `busy`: ignored; `prog_len` is not re-latched.
- `count_done` seen outside WAIT: ignored.
- A `count_done` that stays high from the previous step cannot leak into the next step, because ARM clears the counter first.
- Index arithmetic is STEP_AW+1 wide; a `prog_len` of 2^STEP_AW is legal and wraps cleanly to 0.

## Timing
- Reset values: state IDLE; `valve_out` = 0, `step_addr` = 0, `delay` = 0, `delay_unit` = 0, `timer_clr` = 0, `delay_start` = 0, `cur_step` = 0, `busy` = 0, `done` = 0, `err` = 0.
- From `start` sampled at edge N:
  - FETCH at N+1, LOAD at N+2.
  - `valve_out` and `delay` valid from N+3, which is also ARM.
  - WAIT begins at N+4.
- From `count_done` = 1 sampled in WAIT at edge M:
  - NEXT at M+1, FETCH at M+2.
  - The next mask appears at M+4.
  - Inter-step overhead is 4 cycles; the valve state is unchanged during it.
- `done` is high for exactly the single cycle after NEXT.
- All outputs are registered; none are combinational from inputs.

## Structure
- Shared package `valve_seq_pkg` holds:
  - state encoding localparams;
  - unit-code constants (UNIT_MS … UNIT_DAY, UNIT_MAX = 4);
  - step-word field offsets and widths.
  The top-level and the testbench use the same package.
- No sub-module is needed. The FSM and the datapath registers sit in one module. The delay counter and the step memory are instantiated beside it at the top level, not inside it.

## Test plan
- 3-step program {mask 0x0001, 2 ms}, {0x0003, 0 ms}, {0x8000, 1 ms} with `loop_en` = 0 → `valve_out` steps 0x0001 → 0x0003 → 0x8000; one `done` pulse; `busy` falls the same cycle; `valve_out` stays 0x8000.
- Same program with `loop_en` = 1 → after step 2 the sequencer fetches step 0 again and `valve_out` returns to 0x0001; no `done` pulse.
- Step 1 has unit = 5 → `err` = 1 and `valve_out` = 0 at LOAD+1; `delay_start` never pulses for that step; `start` clears `err`.
- `abort` asserted in WAIT of step 1 → `valve_out` = 0 next cycle; `timer_clr` pulses once; state IDLE; no `done`.
- `prog_len` = 0 with `start` → `done` pulses at N+1; `step_addr` and `valve_out` unchanged; `start` re-pulsed while `busy` on a long step → ignored.
- `rst` asserted asynchronously mid-WAIT → all outputs return to their reset values with no clock edge.
